// File: rtl/seg7_scroll_ctrl.sv
// Scrolling 4-digit multiplexed seven-segment controller with a writable hex
// message buffer and a start/stop/pause sequencer.
module seg7_scroll_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int SCROLL_DIV  = 50000000,
  parameter int MSG_LEN     = 16,
  parameter int PAUSE_STEPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic [6:0] outbin,
  output logic [3:0] outsel
);

  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);
  localparam int HOLD_W   = (PAUSE_STEPS > 0) ? $clog2(PAUSE_STEPS + 1) : 1;

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT   = HOLD_W'(PAUSE_STEPS);
  localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
  localparam logic [3:0]          POS_LAST    = 4'(MSG_LEN - 1);
  localparam logic [4:0]          MSG_LEN5    = 5'(MSG_LEN);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e                state_q, state_d;
  logic [3:0]            pos_q, pos_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [1:0]            digit_q, digit_d;
  logic [SCROLL_W-1:0]   scroll_q, scroll_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [3:0]            msg_q [16];
  logic [6:0]            outbin_q, outbin_d;
  logic [3:0]            outsel_q, outsel_d;
  logic                  tick;
  logic [4:0]            win_sum;
  logic [3:0]            win_idx;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Window index wraps at MSG_LEN explicitly; the sum never exceeds 2*MSG_LEN-1.
  assign win_sum = {1'b0, pos_q} + {3'b000, 2'd3 - digit_q};
  assign win_idx = (win_sum >= MSG_LEN5) ? 4'(win_sum - MSG_LEN5) : win_sum[3:0];

  assign tick = (scroll_q == SCROLL_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    scroll_d = scroll_q;
    hold_d   = hold_q;
    scan_d   = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    digit_d  = (scan_q == SCAN_LAST) ? digit_q - 2'd1 : digit_q;
    outsel_d = ~(4'b0001 << digit_q);
    outbin_d = seg7(msg_q[win_idx]);

    unique case (state_q)
      IDLE: begin
        scroll_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN, HOLD: begin
        scroll_d = tick ? '0 : scroll_q + 1'b1;
        if (tick && state_q == RUN) begin
          if (pos_q == POS_LAST) begin
            pos_d = '0;
            if (PAUSE_STEPS > 0) begin
              state_d = HOLD;
              hold_d  = HOLD_INIT;
            end
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else if (tick) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HOLD_ONE) state_d = RUN;
        end
        // Stop overrides a coincident tick: the window freezes where it is.
        if (stop) begin
          state_d  = IDLE;
          pos_d    = pos_q;
          scroll_d = '0;
          hold_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      scan_q   <= '0;
      digit_q  <= 2'd3;
      scroll_q <= '0;
      hold_q   <= '0;
      outsel_q <= 4'b1111;
      outbin_q <= 7'b1111111;
      // NOTE: the message buffer is reset too, so a reset leaves no stale digits on display.
      for (int i = 0; i < 16; i++) msg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      scroll_q <= scroll_d;
      hold_q   <= hold_d;
      outsel_q <= outsel_d;
      outbin_q <= outbin_d;
      if (wr_en && ({1'b0, wr_addr} < MSG_LEN5)) msg_q[wr_addr] <= wr_data;
    end
  end

  assign busy   = (state_q != IDLE);
  assign outsel = outsel_q;
  assign outbin = outbin_q;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Scoreboard bench for seg7_scroll_ctrl: a behavioural model queues the expected
// outputs at each clock edge; the falling edge pops and compares them.
module tb_seg7_scroll_ctrl;

  localparam int SCAN_DIV    = 4;
  localparam int SCROLL_DIV  = 32;
  localparam int MSG_LEN     = 8;
  localparam int PAUSE_STEPS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic [6:0] outbin;
  logic [3:0] outsel;

  int checks = 0;
  int errors = 0;

  seg7_scroll_ctrl #(
    .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV),
    .MSG_LEN(MSG_LEN), .PAUSE_STEPS(PAUSE_STEPS)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .busy(busy), .outbin(outbin), .outsel(outsel)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] bin;
    logic       busy;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_HOLD} mstate_e;

  exp_t       sb_q[$];
  mstate_e    m_state = M_IDLE;
  int         m_pos = 0, m_scan = 0, m_dig = 3, m_scroll = 0, m_hold = 0;
  logic [3:0] m_msg [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs after each edge, from pre-edge state.
  always @(posedge clk) begin
    exp_t e;
    bit   tk;
    if (!rst) begin
      m_state = M_IDLE; m_pos = 0; m_scan = 0; m_dig = 3; m_scroll = 0; m_hold = 0;
      for (int i = 0; i < 16; i++) m_msg[i] = 4'h0;
      e = '{sel: 4'hF, bin: 7'h7F, busy: 1'b0};
    end else begin
      e.sel = 4'hF;
      e.sel[m_dig] = 1'b0;
      e.bin = seg_tab[m_msg[(m_pos + 3 - m_dig) % MSG_LEN]];
      tk = (m_state != M_IDLE) && (m_scroll == SCROLL_DIV - 1);
      if (m_scan == SCAN_DIV - 1) begin
        m_scan = 0;
        m_dig = (m_dig == 0) ? 3 : m_dig - 1;
      end else m_scan++;
      if (wr_en && wr_addr < MSG_LEN) m_msg[wr_addr] = wr_data;
      case (m_state)
        M_IDLE: if (start && !stop) m_state = M_RUN;
        M_RUN: begin
          if (stop) begin m_state = M_IDLE; m_scroll = 0; end
          else if (tk) begin
            m_scroll = 0;
            if (m_pos == MSG_LEN - 1) begin
              m_pos = 0;
              if (PAUSE_STEPS > 0) begin m_state = M_HOLD; m_hold = PAUSE_STEPS; end
            end else m_pos++;
          end else m_scroll++;
        end
        default: begin
          if (stop) begin m_state = M_IDLE; m_scroll = 0; m_hold = 0; end
          else if (tk) begin
            m_scroll = 0;
            m_hold--;
            if (m_hold == 0) m_state = M_RUN;
          end else m_scroll++;
        end
      endcase
      e.busy = (m_state != M_IDLE);
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_outsel", outsel, e.sel);
      check("sb_outbin", outbin, e.bin);
      check("sb_busy", busy, e.busy);
    end
  end

  // Observe one full scan (16 cycles); win[4k+3:4k] is the digit expected at position k.
  task automatic check_window(input logic [15:0] win);
    logic [3:0] seen = '0;
    int k;
    repeat (4 * SCAN_DIV) begin
      @(negedge clk);
      case (outsel)
        4'b0111: k = 3;
        4'b1011: k = 2;
        4'b1101: k = 1;
        4'b1110: k = 0;
        default: k = -1;
      endcase
      if (k >= 0) begin
        seen[k] = 1'b1;
        check("win_digit", outbin, seg_tab[win[k*4 +: 4]]);
      end
    end
    check("win_scan", seen, 4'hF);
  endtask

  task automatic wait_pos(input int p, input int budget);
    int n = 0;
    while (m_pos != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_pos != p) check("timeout_pos", 32'(m_pos), 32'(p));
  endtask

  task automatic write_digit(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic do_start, input logic do_stop);
    @(negedge clk);
    start = do_start; stop = do_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("first_outsel", outsel, 4'b0111);
    check("first_outbin", outbin, 7'b1000000);
    check("reset_busy", busy, 1'b0);
    check_window(16'h0000);

    for (int i = 0; i < MSG_LEN; i++) write_digit(4'(i), 4'(i + 1));
    check_window(16'h1234);

    pulse(1'b1, 1'b0);
    check("start_busy", busy, 1'b1);
    wait_pos(1, 40);
    check_window(16'h2345);
    wait_pos(7, 250);
    check_window(16'h8123);
    wait_pos(0, 40);
    check_window(16'h1234);
    check("hold_busy", busy, 1'b1);
    repeat (47) @(negedge clk);
    check_window(16'h1234);
    wait_pos(1, 40);
    check_window(16'h2345);

    wait_pos(3, 80);
    pulse(1'b0, 1'b1);
    check("stop_busy", busy, 1'b0);
    repeat (200) @(negedge clk);
    check_window(16'h4567);
    pulse(1'b1, 1'b0);
    check_window(16'h4567);
    repeat (16) @(negedge clk);
    check_window(16'h5678);

    write_digit(4'd6, 4'hE);
    pulse(1'b1, 1'b1);
    check("startstop_busy", busy, 1'b0);
    write_digit(4'd9, 4'h0);
    write_digit(4'd12, 4'h0);
    check_window(16'h56E8);

    pulse(1'b1, 1'b0);
    begin
      int n = 0;
      while (m_state != M_HOLD && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (m_state != M_HOLD) check("timeout_hold", 32'(m_state), 32'(M_HOLD));
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_outsel", outsel, 4'b1111);
    check("rst_outbin", outbin, 7'b1111111);
    check("rst_busy", busy, 1'b0);
    check_window(16'h0000);
    check("rst_busy_after", busy, 1'b0);
    repeat (40) @(negedge clk);
    check_window(16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
